// File: rtl/reg_serializer_pkg.sv
// Shared definitions for the register unload serializer: FSM encoding and a
// counter-width helper.
package reg_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Width needed to count 0..n-1, never less than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/reg_serializer_beat_counter.sv
// Beat index counter for the serializer; flags the final beat of a word.
module beat_counter #(
    parameter int CW  = 1,
    parameter int MAX = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic at_max
);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign at_max = (count == CW'(MAX));

endmodule

// File: rtl/reg_serializer.sv
// Parallel-load, W-bit-per-beat serializer for an N-bit register word.
// Handshake: a beat moves when ser_valid & ser_ready at a rising edge; a word is captured when load_signal & in_ready.
module reg_serializer
    import reg_pkg::*;
#(
    parameter int N         = 64,
    parameter int W         = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_signal,
    input  logic [N-1:0] data_input,
    output logic         in_ready,
    output logic         ser_valid,
    input  logic         ser_ready,
    output logic [W-1:0] ser_data,
    output logic         ser_last,
    output state_t       dbg_state
);

    localparam int BEATS = N / W;
    localparam int CW    = clog2_min1(BEATS);

    if (N % W != 0) begin : g_bad_width
        $error("reg_serializer: N must be a multiple of W");
    end

    state_t       state;
    state_t       state_next;
    logic [N-1:0] shreg;
    logic [N-1:0] shreg_shifted;
    logic         transfer;
    logic         capture;

    assign ser_valid = (state == ST_SHIFT);
    assign transfer  = ser_valid & ser_ready;
    assign in_ready  = (state == ST_IDLE) | (transfer & ser_last);
    assign capture   = load_signal & in_ready;
    assign dbg_state = state;

    // Emitting end is fixed at elaboration; the register always drains toward it.
    if (MSB_FIRST) begin : g_msb
        assign ser_data      = shreg[N-1 -: W];
        assign shreg_shifted = shreg << W;
    end else begin : g_lsb
        assign ser_data      = shreg[W-1:0];
        assign shreg_shifted = shreg >> W;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (capture) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (transfer && ser_last) state_next = capture ? ST_SHIFT : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            shreg <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                shreg <= data_input;
            end else if (transfer) begin
                shreg <= shreg_shifted;
            end
        end
    end

    beat_counter #(
        .CW  (CW),
        .MAX (BEATS - 1)
    ) u_beat_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (capture),
        .inc    (transfer & ~ser_last),
        .at_max (ser_last)
    );

endmodule
